bus_init_sequencer: RTL and testbench

Sequences the power-up and oscillator trimming of the MOPSHUB CAN buses after reset. On a start request it walks bus indices 0..n_buses, pulses the power enable for each bus, waits a settle interval, and optionally issues a trim request and waits for completion or timeout. It sits between the hub's top-level initialisation control and the per-bus power/trim logic. It drives `power_bus_en`, `power_bus_cnt`, `start_trim_ack`, `end_trim_bus` and `end_power_init`.

---
 rtl/bus_init_sequencer_if.sv | 28 ++
 rtl/bus_init_sequencer.sv | 124 ++++++++++++
 tb/tb_bus_init_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_init_sequencer_if.sv
// Handshake bundle between the hub init controller, the power/trim logic and
// the bus init sequencer.
interface bus_init_sequencer_if;
    logic        start_init;
    logic [4:0]  n_buses;
    logic        osc_auto_trim;
    logic        trim_done;
    logic        abort;
    logic        power_bus_en;
    logic [4:0]  power_bus_cnt;
    logic        start_trim_ack;
    logic        end_trim_bus;
    logic        end_power_init;
    logic        busy;
    logic [15:0] fail_mask;

    modport master (
        output start_init, n_buses, osc_auto_trim, trim_done, abort,
        input  power_bus_en, power_bus_cnt, start_trim_ack, end_trim_bus,
               end_power_init, busy, fail_mask
    );

    modport slave (
        input  start_init, n_buses, osc_auto_trim, trim_done, abort,
        output power_bus_en, power_bus_cnt, start_trim_ack, end_trim_bus,
               end_power_init, busy, fail_mask
    );
endinterface

// File: rtl/bus_init_sequencer.sv
// Walks the CAN buses after reset: power pulse, settle wait, optional oscillator
// trim with timeout, then reports completion and the per-bus trim failures.
module bus_init_sequencer #(
    parameter int SETTLE_CYC   = 16,
    parameter int TRIM_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_init_sequencer_if.slave  bus
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = (TRIM_TIMEOUT > 1) ? $clog2(TRIM_TIMEOUT) : 1;
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TRIM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, POWER, SETTLE, TRIM_REQ, TRIM_WAIT, NEXT, DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     last_q, last_d;
    logic           trim_en_q, trim_en_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [TW-1:0]  timeout_q, timeout_d;
    logic [15:0]    fail_mask_q, fail_mask_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            trim_en_q   <= 1'b0;
            settle_q    <= '0;
            timeout_q   <= '0;
            fail_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            trim_en_q   <= trim_en_d;
            settle_q    <= settle_d;
            timeout_q   <= timeout_d;
            fail_mask_q <= fail_mask_d;
        end
    end

    // Abort overrides every transition but leaves the bus index and fail mask untouched.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        trim_en_d   = trim_en_q;
        settle_d    = settle_q;
        timeout_d   = timeout_q;
        fail_mask_d = fail_mask_q;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_init) begin
                        last_d      = (bus.n_buses > 5'd15) ? 4'd15 : bus.n_buses[3:0];
                        trim_en_d   = bus.osc_auto_trim;
                        cnt_d       = '0;
                        fail_mask_d = '0;
                        state_d     = POWER;
                    end
                end
                POWER: begin
                    settle_d = '0;
                    state_d  = SETTLE;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = trim_en_q ? TRIM_REQ : NEXT;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                TRIM_REQ: begin
                    timeout_d = '0;
                    state_d   = TRIM_WAIT;
                end
                TRIM_WAIT: begin
                    if (bus.trim_done) begin
                        state_d = NEXT;
                    end else if (timeout_q == TIMEOUT_LAST) begin
                        fail_mask_d = fail_mask_q | (16'd1 << cnt_q);
                        state_d     = NEXT;
                    end else begin
                        timeout_d = timeout_q + 1'b1;
                    end
                end
                NEXT: begin
                    if (cnt_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = POWER;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NEXT is only ever reached through TRIM_WAIT while trimming is enabled.
    assign bus.power_bus_en   = (state_q == POWER);
    assign bus.power_bus_cnt  = {1'b0, cnt_q};
    assign bus.start_trim_ack = (state_q == TRIM_REQ);
    assign bus.end_trim_bus   = (state_q == NEXT) && trim_en_q;
    assign bus.end_power_init = (state_q == DONE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.fail_mask      = fail_mask_q;

endmodule

// File: tb/tb_bus_init_sequencer.sv
// Scoreboard bench for bus_init_sequencer: directed runs push the expected pulse
// events (kind, bus index, cycle since start) and a monitor pops and compares them.
module tb_bus_init_sequencer;

    localparam int K_PWR  = 0;
    localparam int K_ACK  = 1;
    localparam int K_ETRM = 2;
    localparam int K_END  = 3;

    typedef struct {
        int kind;
        int cnt;
        int cyc;
        int mask;
    } ev_t;

    logic clk;
    logic rst;
    bus_init_sequencer_if bus_if ();

    bus_init_sequencer #(
        .SETTLE_CYC   (4),
        .TRIM_TIMEOUT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  edge_cnt = 0;
    int  start_edge = 0;
    int  last_end_cyc = 0;
    bit  ignore_events = 0;
    int  trim_delay[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic pushEvent(input int kind, input int cnt, input int cyc, input int mask);
        ev_t e;
        e.kind = kind;
        e.cnt  = cnt;
        e.cyc  = cyc;
        e.mask = mask;
        exp_q.push_back(e);
    endtask

    // Expected pulses for a complete run with SETTLE_CYC=4; t[b] is the TRIM_WAIT length of bus b.
    task automatic pushRun(input int last, input bit trim, input int t[16], input int mask);
        int p = 1;
        for (int b = 0; b <= last; b++) begin
            pushEvent(K_PWR, b, p, 0);
            if (trim) begin
                pushEvent(K_ACK, b, p + 5, 0);
                pushEvent(K_ETRM, b, p + 6 + t[b], 0);
                p = p + 7 + t[b];
            end else begin
                p = p + 6;
            end
        end
        pushEvent(K_END, last, p, mask);
    endtask

    task automatic applyStimulus(input int n, input bit trim);
        @(negedge clk);
        bus_if.n_buses       = 5'(n);
        bus_if.osc_auto_trim = trim;
        bus_if.start_init    = 1'b1;
        @(posedge clk);
        #1 start_edge = edge_cnt;
        @(negedge clk);
        bus_if.start_init = 1'b0;
    endtask

    task automatic waitDrained(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput({name, "_pending_events"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        checkOutput({name, "_busy_after"}, int'(bus_if.busy), 0);
    endtask

    task automatic observe(input int kind);
        ev_t e;
        int  cyc;
        int  cnt;
        int  mask;
        cyc  = edge_cnt - start_edge + 1;
        cnt  = int'(bus_if.power_bus_cnt);
        mask = (kind == K_END) ? int'(bus_if.fail_mask) : 0;
        if (kind == K_END) last_end_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected_event actual kind=%0d cnt=%0d cyc=%0d expected no event",
                     kind, cnt, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cnt != cnt || e.cyc != cyc || e.mask != mask) begin
                failures++;
                $display("[TB] FAIL event actual kind=%0d cnt=%0d cyc=%0d mask=%h expected kind=%0d cnt=%0d cyc=%0d mask=%h",
                         kind, cnt, cyc, mask, e.kind, e.cnt, e.cyc, e.mask);
            end
        end
    endtask

    // Monitor: at most one pulse output can be high per cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !ignore_events) begin
                if (bus_if.power_bus_en)   observe(K_PWR);
                if (bus_if.start_trim_ack) observe(K_ACK);
                if (bus_if.end_trim_bus)   observe(K_ETRM);
                if (bus_if.end_power_init) observe(K_END);
            end
        end
    end

    // Trim responder: answers each request after trim_delay[bus] cycles; 0 withholds the answer.
    initial begin
        int d;
        bus_if.trim_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus_if.start_trim_ack) begin
                d = trim_delay[bus_if.power_bus_cnt[3:0]];
                if (d > 0) begin
                    repeat (d) @(negedge clk);
                    bus_if.trim_done = 1'b1;
                    @(negedge clk);
                    bus_if.trim_done = 1'b0;
                end
            end
        end
    end

    initial begin
        int t[16];
        rst                  = 1'b1;
        bus_if.start_init    = 1'b0;
        bus_if.n_buses       = 5'd0;
        bus_if.osc_auto_trim = 1'b0;
        bus_if.abort         = 1'b0;
        for (int i = 0; i < 16; i++) trim_delay[i] = 3;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", int'(bus_if.busy), 0);
        checkOutput("reset_cnt", int'(bus_if.power_bus_cnt), 0);
        checkOutput("reset_mask", int'(bus_if.fail_mask), 0);
        checkOutput("reset_pulses", int'({bus_if.power_bus_en, bus_if.start_trim_ack,
                                          bus_if.end_trim_bus, bus_if.end_power_init}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 16 buses without trim: pulses every 6 cycles, done on cycle 97.
        for (int i = 0; i < 16; i++) t[i] = 0;
        pushRun(15, 1'b0, t, 0);
        applyStimulus(15, 1'b0);
        waitDrained("no_trim", 300);
        checkOutput("no_trim_end_cycle", last_end_cyc, 97);

        // Three buses trimmed with a 3-cycle handshake.
        for (int i = 0; i < 16; i++) t[i] = 3;
        pushRun(2, 1'b1, t, 0);
        applyStimulus(2, 1'b1);
        waitDrained("trim", 200);
        checkOutput("trim_end_cycle", last_end_cyc, 31);
        checkOutput("trim_mask", int'(bus_if.fail_mask), 16'h0000);

        // Bus 1 times out after 8 cycles of waiting.
        trim_delay[1] = 0;
        t[1] = 8;
        pushRun(3, 1'b1, t, 16'h0002);
        applyStimulus(3, 1'b1);
        waitDrained("timeout", 300);
        checkOutput("timeout_end_cycle", last_end_cyc, 46);
        checkOutput("timeout_mask", int'(bus_if.fail_mask), 16'h0002);
        repeat (10) @(negedge clk);

        // trim_done already present on entry, then on the last timeout cycle.
        trim_delay[0] = 1;
        trim_delay[1] = 8;
        t[0] = 1;
        t[1] = 8;
        pushRun(1, 1'b1, t, 16'h0000);
        applyStimulus(1, 1'b1);
        waitDrained("late_done", 200);
        checkOutput("late_done_end_cycle", last_end_cyc, 24);
        checkOutput("late_done_mask", int'(bus_if.fail_mask), 16'h0000);

        // n_buses=31 saturates; a mid-run start with new settings is ignored.
        for (int i = 0; i < 16; i++) t[i] = 0;
        pushRun(15, 1'b0, t, 0);
        applyStimulus(31, 1'b0);
        repeat (18) @(negedge clk);
        bus_if.osc_auto_trim = 1'b1;
        bus_if.n_buses       = 5'd3;
        bus_if.start_init    = 1'b1;
        @(negedge clk);
        bus_if.start_init = 1'b0;
        waitDrained("saturate", 300);
        checkOutput("saturate_end_cycle", last_end_cyc, 97);

        // Abort during bus 5 SETTLE with bus 1 already failed.
        for (int i = 0; i < 16; i++) trim_delay[i] = 3;
        trim_delay[1] = 0;
        for (int b = 0; b < 5; b++) begin
            pushEvent(K_PWR, b, (b == 0) ? 1 : (b == 1) ? 11 : 16 + 10 * (b - 1), 0);
            pushEvent(K_ACK, b, ((b == 0) ? 1 : (b == 1) ? 11 : 16 + 10 * (b - 1)) + 5, 0);
            pushEvent(K_ETRM, b, (b == 0) ? 10 : (b == 1) ? 25 : 25 + 10 * (b - 1), 0);
        end
        pushEvent(K_PWR, 5, 56, 0);
        applyStimulus(7, 1'b1);
        repeat (57) @(negedge clk);
        bus_if.abort = 1'b1;
        @(negedge clk);
        bus_if.abort = 1'b0;
        checkOutput("abort_busy", int'(bus_if.busy), 0);
        checkOutput("abort_cnt", int'(bus_if.power_bus_cnt), 5);
        checkOutput("abort_mask", int'(bus_if.fail_mask), 16'h0002);
        checkOutput("abort_pending_events", exp_q.size(), 0);
        repeat (20) @(negedge clk);

        // Abort wins over a simultaneous start in IDLE.
        bus_if.abort      = 1'b1;
        bus_if.start_init = 1'b1;
        @(negedge clk);
        bus_if.abort      = 1'b0;
        bus_if.start_init = 1'b0;
        checkOutput("abort_vs_start_busy", int'(bus_if.busy), 0);
        checkOutput("abort_vs_start_mask", int'(bus_if.fail_mask), 16'h0002);

        // A fresh start after abort begins again at bus 0.
        pushRun(0, 1'b0, t, 0);
        applyStimulus(0, 1'b0);
        waitDrained("restart", 100);
        checkOutput("restart_end_cycle", last_end_cyc, 7);

        // Asynchronous reset in the middle of bus 3.
        ignore_events = 1'b1;
        applyStimulus(7, 1'b1);
        repeat (39) @(negedge clk);
        checkOutput("pre_reset_cnt", int'(bus_if.power_bus_cnt), 3);
        checkOutput("pre_reset_mask", int'(bus_if.fail_mask), 16'h0002);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    int'({bus_if.busy, bus_if.power_bus_cnt, bus_if.fail_mask, bus_if.power_bus_en,
                          bus_if.start_trim_ack, bus_if.end_trim_bus, bus_if.end_power_init}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("post_reset_busy", int'(bus_if.busy), 0);
        exp_q.delete();
        ignore_events = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global bound so the run always ends even if the DUT stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=expired expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
